// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported memory between the instruction-fetch port and the
//   load/store port. At most one access is granted and issued per cycle; data
//   wins conflicts unless fetch has lost FAIR_MAX conflicts in a row. Read data
//   comes back RD_LAT cycles after issue and is steered by a {valid, owner}
//   shift register.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   if_req/addr/gnt     fetch request side; if_rvalid/if_rdata fetch response
//   d_req/we/addr/wdata/strb/gnt   data request side; d_rvalid/d_rdata response
//   mem_en/we/addr/wdata/strb      memory issue; mem_rdata_i memory read data
module mem_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int FAIR_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_strb_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_strb_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [3:0] FAIR_LIM = 4'(FAIR_MAX);

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [RD_LAT-1:0] rvld_q, rvld_d;   // return pipe valid bits
    logic [RD_LAT-1:0] rown_q, rown_d;   // return pipe owner: 1 = data port
    logic              fetch_wins;
    logic              rd_issue;

    // Fetch wins only when it is alone, or when it has been starved long enough.
    always_comb begin
        fetch_wins = if_req_i && (!d_req_i || (starve_cnt_q == FAIR_LIM));
        if_gnt_o   = reset && fetch_wins;
        d_gnt_o    = reset && d_req_i && !fetch_wins;
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;
        if (if_gnt_o) begin
            mem_en_o   = 1'b1;
            mem_addr_o = if_addr_i;
        end else if (d_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_strb_o  = d_strb_i;
        end
    end

    assign rd_issue = if_gnt_o || (d_gnt_o && !d_we_i);

    // Counter tracks consecutive conflict losses by fetch; any cycle without a
    // fetch request, or a fetch grant, ends the streak.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt_o || !if_req_i) begin
            starve_cnt_d = '0;
        end else if (d_gnt_o && (starve_cnt_q != FAIR_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        rvld_d    = '0;
        rown_d    = '0;
        rvld_d[0] = rd_issue;
        rown_d[0] = d_gnt_o;
        for (int i = 1; i < RD_LAT; i++) begin
            rvld_d[i] = rvld_q[i-1];
            rown_d[i] = rown_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
            rvld_q       <= '0;
            rown_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rvld_q       <= rvld_d;
            rown_q       <= rown_d;
        end
    end

    assign if_rvalid_o = rvld_q[RD_LAT-1] && !rown_q[RD_LAT-1];
    assign d_rvalid_o  = rvld_q[RD_LAT-1] &&  rown_q[RD_LAT-1];
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int RD_LAT   = 2;
    localparam int FAIR_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_strb;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_strb;

    mem_arbiter #(.RD_LAT(RD_LAT), .FAIR_MAX(FAIR_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_strb_i(d_strb), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // ---------------- memory environment (driven by DUT issue) ------------
    bit   [31:0] env_mem [128];
    logic [31:0] env_pipe [RD_LAT];
    assign mem_rdata = env_pipe[RD_LAT-1];

    always @(posedge clk) begin
        env_pipe[0] <= (mem_en && !mem_we) ? env_mem[mem_addr[8:2]] : $urandom;
        for (int i = 1; i < RD_LAT; i++) env_pipe[i] <= env_pipe[i-1];
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_strb[b]) env_mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    // ---------------- reference model + scoreboard ------------------------
    typedef struct {
        bit          owner;   // 1 = data port
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t        sbq[$];
    bit   [31:0] ref_mem [128];
    int          starve_m = 0;
    bit          gi_last = 0, gd_last = 0;

    // Predicts arbitration from the stated rules, checks the issue side,
    // and pushes expected read responses.
    initial begin
        forever begin
            bit          ei, ed;
            logic [31:0] ea, ew;
            logic [3:0]  es;
            @(negedge clk);
            ei = 0; ed = 0;
            if (!reset) starve_m = 0;
            else begin
                ei = if_req && (!d_req || starve_m == FAIR_MAX);
                ed = d_req && !ei;
            end
            ea = ei ? if_addr : (ed ? d_addr : 32'h0);
            ew = ed ? d_wdata : 32'h0;
            es = ed ? d_strb  : 4'h0;
            check("if_gnt",    if_gnt,    ei);
            check("d_gnt",     d_gnt,     ed);
            check("mem_en",    mem_en,    ei | ed);
            check("mem_we",    mem_we,    ed & d_we);
            check("mem_addr",  mem_addr,  ea);
            check("mem_wdata", mem_wdata, ew);
            check("mem_strb",  mem_strb,  es);
            if (reset) begin
                if (ei) sbq.push_back('{1'b0, ref_mem[if_addr[8:2]], cyc + RD_LAT});
                if (ed && !d_we) sbq.push_back('{1'b1, ref_mem[d_addr[8:2]], cyc + RD_LAT});
                if (ed && d_we)
                    for (int b = 0; b < 4; b++)
                        if (d_strb[b]) ref_mem[d_addr[8:2]][8*b +: 8] = d_wdata[8*b +: 8];
                if (ei || !if_req) starve_m = 0;
                else if (ed && starve_m < FAIR_MAX) starve_m++;
            end
            gi_last = ei;
            gd_last = ed;
        end
    end

    // Monitor: every cycle, either the head response is due and must appear
    // on the right port with the right data, or no rvalid may be seen.
    initial begin
        forever begin
            rsp_t r;
            @(negedge clk);
            if (!reset) begin
                sbq.delete();
                check("rst_if_rvalid", if_rvalid, 0);
                check("rst_d_rvalid",  d_rvalid,  0);
            end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
                r = sbq.pop_front();
                check("if_rvalid", if_rvalid, !r.owner);
                check("d_rvalid",  d_rvalid,  r.owner);
                check("rdata", r.owner ? d_rdata : if_rdata, r.data);
            end else begin
                check("idle_if_rvalid", if_rvalid, 0);
                check("idle_d_rvalid",  d_rvalid,  0);
            end
        end
    end

    // ---------------- stimulus --------------------------------------------
    // Requests stay held with stable payload until granted.
    task automatic step(input bit want_if, input logic [31:0] ia,
                        input bit want_d, input bit we, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] st);
        @(posedge clk); #1;
        if (!if_req || gi_last) begin
            if_req = want_if;
            if (want_if) if_addr = ia;
        end
        if (!d_req || gd_last) begin
            d_req = want_d;
            if (want_d) begin
                d_we = we; d_addr = da; d_wdata = wd; d_strb = st;
            end
        end
    endtask

    function automatic logic [31:0] raddr();
        return {23'h0, 7'($urandom_range(0, 127)), 2'b00};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 0;
        if_req = 1; if_addr = 32'h80;
        d_req = 1; d_we = 0; d_addr = 32'h84; d_wdata = 0; d_strb = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;          // first cycle out of reset: data must win
        idle(6);

        // lone fetch of a word written first
        step(0, 0, 1, 1, 32'h40, 32'h1234_5678, 4'hF);
        idle(1);
        step(1, 32'h40, 0, 0, 0, 0, 0);
        idle(4);

        // partial store then load back
        step(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
        idle(1);
        step(0, 0, 1, 0, 32'h100, 0, 0);
        idle(4);

        // starvation: both ports continuously loading
        for (int i = 0; i < 22; i++) step(1, raddr(), 1, 0, raddr(), 0, 0);
        idle(5);

        // back-to-back alternation
        for (int i = 0; i < 8; i++) step(i % 2 == 0, raddr(), i % 2 == 1, 0, raddr(), 0, 0);
        idle(5);

        // reset one cycle after a load issue
        step(0, 0, 1, 0, 32'h100, 0, 0);
        @(posedge clk); #1;
        reset = 0; d_req = 0; if_req = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        idle(4);
        for (int i = 0; i < 12; i++) step(1, raddr(), 1, 0, raddr(), 0, 0);
        idle(5);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), raddr(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), raddr(), $urandom, 4'($urandom));
        idle(8);
        check("sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
